aes256_encrypt_iter: RTL and testbench
======================================

Name: aes256_encrypt_iter

Overview:
Iterative AES-256 encryption core (FIPS-197) for the transmitter side of the link. It produces the ciphertext that the receiver-side AES-256 decryption path consumes.
- Executes one cipher round per clock and expands the key schedule on the fly, so no 15-entry round-key table is built.
- Uses valid/ready handshakes on both sides and processes one block at a time.

Parameters:
- N, 128, block width in bits; only 128 is legal.
- NR, 14, number of rounds; only 14 is legal (AES-256).
- NK, 8, key length in 32-bit words; only 8 is legal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  core can accept a block.
- in_data  input  N  plaintext; [127:120] is byte 0 (FIPS-197 column-major order).
- key  input  256  cipher key; [255:248] is key byte 0.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts the ciphertext.
- out_data  output  N  ciphertext, same byte order as in_data.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While rst is sampled high at an edge:
  - state becomes IDLE and the round counter becomes 0;
  - out_valid=0, out_data=0, busy=0;
  - the state, key-window and Rcon registers are cleared.
- in_ready: equals (state==IDLE) && !rst.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when in_valid && in_ready at an edge (the accept edge, T). At T:
  - state register = in_data ^ key[255:128] (initial AddRoundKey);
  - key window: kprev = key[255:128], kcur = key[127:0];
  - rnd = 1, rcon = 8'h01.
- RUN, edges T+1 .. T+14: one round per edge using round key rk[rnd].
  - rnd 1..13: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - rnd 14: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
- Round-key generation: rk[1] = kcur as loaded. Each RUN edge after its round computes the next key from (kprev, kcur) and shifts the window (kprev <= kcur, kcur <= new).
  - Next key index even (2j): temp = SubWord(RotWord(kcur.w3)) ^ {rcon,24'h0}; after use, rcon <= xtime(rcon).
  - Next key index odd: temp = SubWord(kcur.w3); no rotate, no Rcon.
  - In both cases: w0 = kprev.w0 ^ temp, w1 = kprev.w1 ^ w0, w2 = kprev.w2 ^ w1, w3 = kprev.w3 ^ w2.
- RUN -> DONE at edge T+14:
  - out_data is loaded with the final state;
  - out_valid = 1 from T+14;
  - latency from accept to out_valid is 14 cycles.
- DONE:
  - out_data and out_valid are held stable until out_valid && out_ready at an edge.
  - At that edge: out_valid=0, state -> IDLE, and in_ready=1 in the following cycle.
  - No pass-through from DONE to RUN.
  - Peak throughput is 1 block per 16 cycles with out_ready tied high.
- Ignored inputs:
  - in_valid while busy is ignored; no capture and no error.
  - in_data and key are sampled only at the accept edge; later changes do not affect the block in flight.
- Reset mid-operation (RUN or DONE): the block is discarded, the core returns to IDLE, and no out_valid pulse follows.
- Datapath: S-box and xtime are combinational in-module functions or ROMs; no multicycle paths. All arithmetic is in GF(2^8) with polynomial 0x11B.

Test Plan:
1. FIPS-197 C.3: key=000102…1e1f, in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_data=8ea2b7ca516745bfeafc49904b496089 with out_valid rising exactly 14 cycles after the accept edge, and in_ready=1 two cycles later.
2. All-zero key and all-zero plaintext -> out_data=dc95c078a2408989ad48a21492842087.
3. Backpressure: run vector 1 with out_ready=0 for 20 cycles after out_valid, then 1 -> out_data and out_valid stay stable throughout; exactly one transfer occurs; in_ready stays 0 until the cycle after the transfer.
4. Accept vector 1, then pulse in_valid with vector 2 data and toggle key on every cycle of RUN -> result still 8ea2b7ca…4b496089, and vector 2 is not captured.
5. Assert rst for one cycle at T+7 -> out_valid never rises for that block, busy=0 and in_ready=1 after the reset edge. A fresh vector 1 then yields the correct ciphertext.
6. Back-to-back with in_valid and out_ready held high, vectors 1, 2, 1 -> three outputs in order, each spaced 16 cycles apart, each matching its reference ciphertext.

Source files
------------

// File: rtl/aes256_encrypt_iter_if.sv
// Handshake bundle for the iterative AES-256 encryption core.
// Carries the plaintext/key request side and the ciphertext response side.
interface aes256_encrypt_iter_if #(
    parameter int unsigned N  = 128,
    parameter int unsigned KW = 256
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [KW-1:0] key;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    modport master (
        output in_valid, in_data, key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes256_encrypt_iter.sv
// Iterative AES-256 encryption core: one round per clock, key schedule expanded
// on the fly from a two-round-key sliding window (kprev, kcur).
module aes256_encrypt_iter #(
    parameter int unsigned N  = 128,
    parameter int unsigned NR = 14,
    parameter int unsigned NK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    aes256_encrypt_iter_if.slave bus
);

    localparam int unsigned KW = 32 * NK;
    localparam int unsigned RW = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_e         state_q, state_d;
    logic [N-1:0]   st_q, st_d;
    logic [N-1:0]   kprev_q, kprev_d;
    logic [N-1:0]   kcur_q, kcur_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [RW-1:0]  rnd_q, rnd_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic           accept_c, step_c, last_c, release_c;
    logic [N-1:0]   sb_c, mc_c, round_c, next_key_c;
    logic [31:0]    temp_c;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // SubBytes + ShiftRows, then MixColumns; byte i of the block sits at row i%4, column i/4
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0   = '0;
        a1   = '0;
        a2   = '0;
        a3   = '0;
        sb_c = '0;
        mc_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb_c[N-1-8*(r+4*c) -: 8] = SBOX[st_q[N-1-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sb_c[N-1-32*c  -: 8];
            a1 = sb_c[N-9-32*c  -: 8];
            a2 = sb_c[N-17-32*c -: 8];
            a3 = sb_c[N-25-32*c -: 8];
            mc_c[N-1-32*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc_c[N-9-32*c  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc_c[N-17-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc_c[N-25-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        round_c = ((rnd_q == RW'(NR)) ? sb_c : mc_c) ^ kcur_q;
    end

    // Next round key; odd rnd means the following key index is even (RotWord + Rcon)
    always_comb begin
        temp_c = rnd_q[0] ? (subword({kcur_q[23:0], kcur_q[31:24]}) ^ {rcon_q, 24'h0})
                          : subword(kcur_q[31:0]);
        next_key_c[127:96] = kprev_q[127:96] ^ temp_c;
        next_key_c[95:64]  = kprev_q[95:64]  ^ next_key_c[127:96];
        next_key_c[63:32]  = kprev_q[63:32]  ^ next_key_c[95:64];
        next_key_c[31:0]   = kprev_q[31:0]   ^ next_key_c[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            kprev_q     <= '0;
            kcur_q      <= '0;
            rcon_q      <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            kprev_q     <= kprev_d;
            kcur_q      <= kcur_d;
            rcon_q      <= rcon_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (release_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_c    = bus.in_valid && bus.in_ready;
        step_c      = (state_q == RUN);
        last_c      = step_c && (rnd_q == RW'(NR));
        release_c   = (state_q == DONE) && out_valid_q && bus.out_ready;
        st_d        = st_q;
        kprev_d     = kprev_q;
        kcur_d      = kcur_q;
        rcon_d      = rcon_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept_c) begin
            st_d    = bus.in_data ^ bus.key[KW-1 -: N];
            kprev_d = bus.key[KW-1 -: N];
            kcur_d  = bus.key[N-1:0];
            rnd_d   = RW'(1);
            rcon_d  = 8'h01;
        end else if (step_c) begin
            st_d    = round_c;
            kprev_d = kcur_q;
            kcur_d  = next_key_c;
            rnd_d   = RW'(rnd_q + RW'(1));
            if (rnd_q[0]) rcon_d = xtime(rcon_q);
            if (last_c) begin
                rnd_d       = '0;
                out_data_d  = round_c;
                out_valid_d = 1'b1;
            end
        end
        if (release_c) out_valid_d = 1'b0;
    end

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
// Bench for aes256_encrypt_iter: FIPS-197 vectors, handshake corner cases and
// random blocks checked against a byte-level AES-256 model built from GF(2^8) math.
module tb_aes256_encrypt_iter;

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT0  = 128'hdc95c078a2408989ad48a21492842087;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes256_encrypt_iter_if bus ();
    aes256_encrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [7:0] m_sbox [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] k);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = m_sbox[s[r+4*((c+r)%4)]];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Returns at the falling edge just after the accept edge, with in_valid dropped
    task automatic send(input logic [127:0] pt, input logic [255:0] k);
        int g;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_before_send", 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        bus.key      = k;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [127:0] ct);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ct = bus.out_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, transfers, idx;
        logic [127:0] ct, snap, rp;
        logic [255:0] rk;
        logic         stable, ov_seen, adv;
        logic [127:0] vp [3];
        logic [255:0] vk [3];
        logic [127:0] ve [3];
        int           ocyc [$];
        logic [127:0] odat [$];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key       = '0;
        bus.out_ready = 1'b1;
        build_sbox();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // FIPS-197 C.3
        send(PT1, KEY1);
        wait_out(lat, ct);
        check("kat1_data", ct, CT1);
        check("kat1_latency", 128'(lat), 128'd14);
        check("kat1_busy_done", 128'(bus.busy), 128'd1);
        check("kat1_in_ready_done", 128'(bus.in_ready), 128'd0);
        @(negedge clk);
        check("kat1_in_ready_after", 128'(bus.in_ready), 128'd1);
        check("kat1_out_valid_after", 128'(bus.out_valid), 128'd0);
        check("kat1_busy_after", 128'(bus.busy), 128'd0);

        // All-zero key and plaintext
        send('0, '0);
        wait_out(lat, ct);
        check("kat0_data", ct, CT0);
        @(negedge clk);

        // Random blocks against the model
        for (int n = 0; n < 6; n++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send(rp, rk);
            wait_out(lat, ct);
            check("rand_data", ct, ref_enc(rp, rk));
            check("rand_latency", 128'(lat), 128'd14);
            @(negedge clk);
        end

        // Backpressure: hold out_ready low for 20 cycles
        bus.out_ready = 1'b0;
        send(PT1, KEY1);
        wait_out(lat, ct);
        snap = ct;
        check("bp_data", ct, CT1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== snap || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", 128'(stable), 128'd1);
        bus.out_ready = 1'b1;
        transfers = (bus.out_valid && bus.out_ready) ? 1 : 0;
        @(negedge clk);
        check("bp_in_ready_after", 128'(bus.in_ready), 128'd1);
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid && bus.out_ready) transfers++;
            @(negedge clk);
        end
        check("bp_transfers", 128'(transfers), 128'd1);

        // Inputs changing during RUN must not disturb the block in flight
        send(PT1, KEY1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            bus.in_valid = lat[0];
            bus.in_data  = '0;
            bus.key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("ign_data", bus.out_data, CT1);
        check("ign_latency", 128'(lat), 128'd14);
        @(negedge clk);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid || bus.busy) ov_seen = 1'b1;
            @(negedge clk);
        end
        check("ign_no_capture", 128'(ov_seen), 128'd0);

        // Reset at T+7 discards the block
        send(PT1, KEY1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 128'(bus.busy), 128'd0);
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) ov_seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_out", 128'(ov_seen), 128'd0);
        send(PT1, KEY1);
        wait_out(lat, ct);
        check("midrst_fresh_data", ct, CT1);
        @(negedge clk);

        // Back-to-back with in_valid and out_ready held high
        vp[0] = PT1; vk[0] = KEY1; ve[0] = CT1;
        vp[1] = '0;  vk[1] = '0;   ve[1] = CT0;
        vp[2] = PT1; vk[2] = KEY1; ve[2] = CT1;
        idx = 0;
        adv = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = vp[0];
        bus.key      = vk[0];
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (bus.in_valid && bus.in_ready) adv = 1'b1;
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx < 3) begin
                    bus.in_data = vp[idx];
                    bus.key     = vk[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                ocyc.push_back(cyc);
                odat.push_back(bus.out_data);
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_count", 128'(odat.size()), 128'd3);
        for (int i = 0; i < odat.size() && i < 3; i++) begin
            check("b2b_data", odat[i], ve[i]);
            if (i > 0) check("b2b_spacing", 128'(ocyc[i] - ocyc[i-1]), 128'd16);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
